pipe_stage_elastic: RTL

//  Parametrised elastic pipeline register with valid/ready handshake, stall, flush and bubble-safe control.

---
 rtl/pipe_stage_elastic_pkg.sv | 28 ++
 rtl/pipe_stage_elastic_slot.sv | 65 ++++++
 rtl/pipe_stage_elastic.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_elastic_pkg.sv
// ============================================================================
// Module   : pipe_stage_elastic_pkg
// Purpose  : Shared limits, default widths and slot command encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_stage_elastic_pkg;

  localparam int DEPTH_MIN  = 1;
  localparam int DEPTH_MAX  = 4;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_CTRL_W = 2;

  typedef enum logic [1:0] {
    SLOT_HOLD  = 2'b00,
    SLOT_LOAD  = 2'b01,
    SLOT_CLEAR = 2'b10
  } slot_op_e;

  // Room for DEPTH slots plus the optional skid entry.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 2);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_stage_elastic_slot.sv
// ============================================================================
// Module   : pipe_slot
// Purpose  : One valid+data+ctrl register with load/clear command.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_slot
  import pipe_stage_elastic_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;

  // Clearing leaves data stale on purpose; only ctrl must read as zero.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    case (op_i)
      SLOT_LOAD: begin
        valid_d = 1'b1;
        data_d  = data_i;
        ctrl_d  = ctrl_i;
      end
      SLOT_CLEAR: begin
        valid_d = 1'b0;
        ctrl_d  = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign ctrl_o  = ctrl_q;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_elastic.sv
// ============================================================================
// Module   : pipe_stage_elastic
// Purpose  : Elastic valid/ready pipeline register, DEPTH slots, with flush.
//            Define PIPE_SKID_BUF_EN for a registered in_ready + skid entry.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_elastic
  import pipe_stage_elastic_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int DEPTH  = 1,
  parameter int OCC_W  = occ_width(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [OCC_W-1:0]  occupancy
);

  if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
    $error("pipe_stage_elastic: DEPTH out of range");
  end

  logic [DEPTH-1:0]  slot_v;
  logic [DEPTH-1:0]  adv;
  logic [DEPTH-1:0]  free;
  logic [DATA_W-1:0] slot_data [DEPTH];
  logic [CTRL_W-1:0] slot_ctrl [DEPTH];

  logic              in_xfer;
  logic              s0_offer;
  logic [DATA_W-1:0] s0_data;
  logic [CTRL_W-1:0] s0_ctrl;
  logic              skid_v;

  // Ready ripples from the output slot back toward slot 0.
  always_comb begin
    adv             = '0;
    free            = '0;
    adv[DEPTH-1]    = slot_v[DEPTH-1] & out_ready & ~flush;
    free[DEPTH-1]   = ~slot_v[DEPTH-1] | adv[DEPTH-1];
    for (int i = DEPTH - 2; i >= 0; i--) begin
      adv[i]  = slot_v[i] & free[i+1];
      free[i] = ~slot_v[i] | adv[i];
    end
  end

`ifdef PIPE_SKID_BUF_EN
  logic              skid_v_q, skid_v_d;
  logic              in_ready_q;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;

  assign in_ready = in_ready_q & reset & ~flush;
  assign in_xfer  = in_valid & in_ready;
  assign s0_offer = skid_v_q | in_xfer;
  assign s0_data  = skid_v_q ? skid_data_q : in_data;
  assign s0_ctrl  = skid_v_q ? skid_ctrl_q : in_ctrl;
  assign skid_v   = skid_v_q;

  // in_ready_q tracks skid emptiness, so input never arrives while skid is full.
  always_comb begin
    skid_v_d    = skid_v_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush) begin
      skid_v_d    = 1'b0;
      skid_ctrl_d = '0;
    end else if (in_xfer && !free[0]) begin
      skid_v_d    = 1'b1;
      skid_data_d = in_data;
      skid_ctrl_d = in_ctrl;
    end else if (skid_v_q && free[0]) begin
      skid_v_d    = 1'b0;
      skid_ctrl_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      skid_v_q    <= 1'b0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      in_ready_q  <= 1'b1;
    end else begin
      skid_v_q    <= skid_v_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      in_ready_q  <= ~skid_v_d;
    end
  end
`else
  assign in_ready = reset & ~flush & free[0];
  assign in_xfer  = in_valid & in_ready;
  assign s0_offer = in_xfer;
  assign s0_data  = in_data;
  assign s0_ctrl  = in_ctrl;
  assign skid_v   = 1'b0;
`endif

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic              load;
    logic [1:0]        op;
    logic [DATA_W-1:0] src_data;
    logic [CTRL_W-1:0] src_ctrl;
    logic              v;

    if (i == 0) begin : g_head
      assign load     = s0_offer & free[0];
      assign src_data = s0_data;
      assign src_ctrl = s0_ctrl;
    end else begin : g_body
      assign load     = adv[i-1];
      assign src_data = slot_data[i-1];
      assign src_ctrl = slot_ctrl[i-1];
    end

    always_comb begin
      op = SLOT_HOLD;
      if (flush) begin
        op = SLOT_CLEAR;
      end else if (load) begin
        op = SLOT_LOAD;
      end else if (adv[i]) begin
        op = SLOT_CLEAR;
      end
    end

    pipe_slot #(
      .DATA_W (DATA_W),
      .CTRL_W (CTRL_W)
    ) u_slot (
      .clk     (clk),
      .reset   (reset),
      .op_i    (op),
      .data_i  (src_data),
      .ctrl_i  (src_ctrl),
      .valid_o (v),
      .data_o  (slot_data[i]),
      .ctrl_o  (slot_ctrl[i])
    );

    assign slot_v[i] = v;
  end

  assign out_valid = slot_v[DEPTH-1] & ~flush;
  assign out_data  = slot_data[DEPTH-1];
  assign out_ctrl  = out_valid ? slot_ctrl[DEPTH-1] : '0;

  always_comb begin
    occupancy = OCC_W'(skid_v);
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + OCC_W'(slot_v[i]);
    end
  end

endmodule

`default_nettype wire
